// File: rtl/oc8051_cxrom_fetch_pkg.sv
// Shared types and constants for the oc8051 cxrom instruction-fetch bridge.
// Prefetch support is controlled by the OC8051_CXROM_PREFETCH_EN macro.
package oc8051_cxrom_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MISS = 2'd1,
      PF   = 2'd2
   } fetch_state_t;

   localparam int unsigned LATENCY_MIN = 1;
   localparam int unsigned LATENCY_MAX = 7;
   localparam int unsigned CNT_W       = 3;

   localparam logic [15:0] ADDR_INC = 16'd4;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/oc8051_cxrom_pfbuf.sv
// Single-entry sequential prefetch buffer (valid/addr/data) with lookup and invalidate.
// Only built when OC8051_CXROM_PREFETCH_EN is defined.
`ifdef OC8051_CXROM_PREFETCH_EN
module oc8051_cxrom_pfbuf
   import oc8051_cxrom_fetch_pkg::*;
#(
   parameter int unsigned AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fill_en,
   input  logic [AW-1:0] fill_addr,
   input  word_t         fill_data,
   input  logic          inv_en,
   input  logic [AW-1:0] lookup_addr,
   output logic          hit,
   output word_t         hit_data,
   output logic          valid,
   output logic [AW-1:0] entry_addr
);

   logic          valid_q, valid_d;
   logic [AW-1:0] addr_q, addr_d;
   word_t         data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (inv_en) begin
         valid_d = 1'b0;
      end else if (fill_en) begin
         valid_d = 1'b1;
         addr_d  = fill_addr;
         data_d  = fill_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign hit        = valid_q & (addr_q == lookup_addr);
   assign hit_data   = data_q;
   assign valid      = valid_q;
   assign entry_addr = addr_q;

endmodule
`endif

// File: rtl/oc8051_cxrom_fetch.sv
// Instruction-fetch bridge from the oc8051 wbi bus to the combinational cxrom.
// Define OC8051_CXROM_PREFETCH_EN to add the one-entry sequential prefetch.
module oc8051_cxrom_fetch
   import oc8051_cxrom_fetch_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned AW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] wbi_adr_i,
   input  logic          wbi_cyc_i,
   input  logic          wbi_stb_i,
   output word_t         wbi_dat_o,
   output logic          wbi_ack_o,
   output logic [AW-1:0] cxrom_addr,
   input  word_t         cxrom_data_in
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   fetch_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   word_t            dat_q, dat_d;
   logic             ack_q, ack_d;
   logic             req;

   // No new request is taken while the previous ack is still on the bus.
   assign req = wbi_cyc_i & wbi_stb_i & ~ack_q;

`ifdef OC8051_CXROM_PREFETCH_EN
   logic [AW-1:0] ack_addr_q, ack_addr_d;
   logic [AW-1:0] pf_next;
   logic          merge_q, merge_d;
   logic          merged;
   logic          pf_fill, pf_inv, pf_hit, pf_valid;
   word_t         pf_hit_data;
   logic [AW-1:0] pf_entry_addr;

   assign pf_next = ack_addr_q + AW'(ADDR_INC);
   // A demand that matched the in-flight prefetch stays merged while the core holds cyc.
   assign merged  = (merge_q & wbi_cyc_i) | req;

   oc8051_cxrom_pfbuf #(
      .AW (AW)
   ) u_pfbuf (
      .clk         (clk),
      .rst         (rst),
      .fill_en     (pf_fill),
      .fill_addr   (addr_q),
      .fill_data   (cxrom_data_in),
      .inv_en      (pf_inv),
      .lookup_addr (wbi_adr_i),
      .hit         (pf_hit),
      .hit_data    (pf_hit_data),
      .valid       (pf_valid),
      .entry_addr  (pf_entry_addr)
   );
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
`ifdef OC8051_CXROM_PREFETCH_EN
      ack_addr_d = ack_addr_q;
      merge_d    = merge_q;
      pf_fill    = 1'b0;
      pf_inv     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
`ifdef OC8051_CXROM_PREFETCH_EN
               if (pf_hit) begin
                  ack_d      = 1'b1;
                  dat_d      = pf_hit_data;
                  ack_addr_d = wbi_adr_i;
               end else begin
`endif
                  state_d = MISS;
                  addr_d  = wbi_adr_i;
                  cnt_d   = CNT_LOAD;
`ifdef OC8051_CXROM_PREFETCH_EN
               end
`endif
            end
`ifdef OC8051_CXROM_PREFETCH_EN
            else if (ack_q && !(pf_valid && (pf_entry_addr == pf_next))) begin
               state_d = PF;
               addr_d  = pf_next;
               cnt_d   = CNT_LOAD;
               merge_d = 1'b0;
            end
`endif
         end
         MISS: begin
            if (!wbi_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
               ack_d   = 1'b1;
               dat_d   = cxrom_data_in;
`ifdef OC8051_CXROM_PREFETCH_EN
               ack_addr_d = addr_q;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`ifdef OC8051_CXROM_PREFETCH_EN
         PF: begin
            if (req && (wbi_adr_i != addr_q)) begin
               pf_inv  = 1'b1;
               merge_d = 1'b0;
               state_d = MISS;
               addr_d  = wbi_adr_i;
               cnt_d   = CNT_LOAD;
            end else if (cnt_q == '0) begin
               pf_fill = 1'b1;
               merge_d = 1'b0;
               state_d = IDLE;
               if (merged) begin
                  ack_d      = 1'b1;
                  dat_d      = cxrom_data_in;
                  ack_addr_d = addr_q;
               end
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               merge_d = merged;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
      end
   end

`ifdef OC8051_CXROM_PREFETCH_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_addr_q <= '0;
         merge_q    <= 1'b0;
      end else begin
         ack_addr_q <= ack_addr_d;
         merge_q    <= merge_d;
      end
   end
`endif

   assign wbi_dat_o  = dat_q;
   assign wbi_ack_o  = ack_q;
   assign cxrom_addr = addr_q;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Self-checking bench for oc8051_cxrom_fetch (LATENCY=2 main instance, LATENCY=1 second instance).
module tb_oc8051_cxrom_fetch;

   localparam int LAT = 2;

   logic        clk, rst;
   logic [15:0] adr, cxa;
   logic        cyc, stb, ack;
   logic [31:0] dat, rom_d;
   logic [15:0] adr1, cxa1;
   logic        cyc1, stb1, ack1;
   logic [31:0] dat1, rom_d1;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] rom(input logic [15:0] a);
      if (a == 16'h0000) return 32'h12345678;
      return {a ^ 16'hC35A, a};
   endfunction

   assign rom_d  = rom(cxa);
   assign rom_d1 = rom(cxa1);

   oc8051_cxrom_fetch #(.LATENCY(LAT), .AW(16)) dut (
      .clk(clk), .rst(rst), .wbi_adr_i(adr), .wbi_cyc_i(cyc), .wbi_stb_i(stb),
      .wbi_dat_o(dat), .wbi_ack_o(ack), .cxrom_addr(cxa), .cxrom_data_in(rom_d));

   oc8051_cxrom_fetch #(.LATENCY(1), .AW(16)) dut1 (
      .clk(clk), .rst(rst), .wbi_adr_i(adr1), .wbi_cyc_i(cyc1), .wbi_stb_i(stb1),
      .wbi_dat_o(dat1), .wbi_ack_o(ack1), .cxrom_addr(cxa1), .cxrom_data_in(rom_d1));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] adr;
      int          gap;
      int          exp_n;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t        vecs [6];
   logic [15:0] tab_a [6] = '{16'h0000, 16'h0004, 16'h0008, 16'hFFFC, 16'h0000, 16'h1234};
   int          tab_g [6] = '{1, 1, 0, 1, 2, 0};
`ifdef OC8051_CXROM_PREFETCH_EN
   int          tab_n [6] = '{3, 2, 3, 3, 1, 4};
`else
   int          tab_n [6] = '{3, 3, 4, 3, 3, 4};
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // n = rising edges from asserting the request until ack is seen.
   task automatic do_req(input logic [15:0] a, input int gap, output int n,
                         output logic [31:0] d, output logic [15:0] ca);
      bit got = 1'b0;
      repeat (gap) @(negedge clk);
      adr = a; cyc = 1'b1; stb = 1'b1;
      n = 0; d = '0; ca = '0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (ack) begin
            got = 1'b1; d = dat; ca = cxa;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL req_timeout adr=%h: no ack after %0d edges", a, n);
         n = -1;
      end
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int          n;
      logic [31:0] d;
      logic [15:0] ca, prev, a, prev1;
      bit          bad, have_prev;
      int          g;

      clk = 1'b0; rst = 1'b0;
      adr = '0; cyc = 1'b0; stb = 1'b0;
      adr1 = '0; cyc1 = 1'b0; stb1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_dat", dat, 0);
      chk("rst_cxa", cxa, 0);
      chk("rst_ack1", ack1, 0);
      rst = 1'b1;

      // Table-driven request sequence.
      for (int i = 0; i < 6; i++)
         vecs[i] = '{tab_a[i], tab_g[i], tab_n[i], rom(tab_a[i])};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         do_req(vecs[i].adr, vecs[i].gap, n, d, ca);
         chk($sformatf("tab%0d_lat", i), n, vecs[i].exp_n);
         chk($sformatf("tab%0d_dat", i), d, vecs[i].exp_dat);
`ifndef OC8051_CXROM_PREFETCH_EN
         chk($sformatf("tab%0d_cxa", i), ca, vecs[i].adr);
`endif
      end

      // First access after reset, then the edge after the ack.
      do_reset();
      do_req(16'h0000, 1, n, d, ca);
      chk("first_lat", n, LAT + 1);
      chk("first_dat", d, 32'h12345678);
      @(negedge clk);
      chk("first_ack_pulse", ack, 0);
`ifdef OC8051_CXROM_PREFETCH_EN
      chk("first_pf_addr", cxa, 16'h0004);
      repeat (3) @(negedge clk);
      do_req(16'h0004, 0, n, d, ca);
      chk("seq_hit_lat", n, 1);
      chk("seq_hit_dat", d, rom(16'h0004));
      @(negedge clk);
      chk("seq_refill_addr", cxa, 16'h0008);

      // Jump while the prefetch of 0x0004 is in flight.
      do_reset();
      do_req(16'h0000, 1, n, d, ca);
      do_req(16'h0100, 0, n, d, ca);
      chk("jump_lat", n, LAT + 2);
      chk("jump_dat", d, rom(16'h0100));

      // Wrap from 0xFFFC to 0x0000.
      do_reset();
      do_req(16'hFFFC, 1, n, d, ca);
      chk("wrap_dat", d, rom(16'hFFFC));
      chk("wrap_cxa", ca, 16'hFFFC);
      @(negedge clk);
      chk("wrap_pf_addr", cxa, 16'h0000);
      repeat (3) @(negedge clk);
      do_req(16'h0000, 0, n, d, ca);
      chk("wrap_hit_lat", n, 1);
      chk("wrap_hit_dat", d, 32'h12345678);
`else
      chk("first_cxa_hold", cxa, 16'h0000);
`endif

      // cyc dropped during a miss.
      do_reset();
      @(negedge clk);
      adr = 16'h0020; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("drop_cxa", cxa, 16'h0020);
      cyc = 1'b0; stb = 1'b0;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ack) bad = 1'b1;
      end
      chk("drop_noack", bad, 0);
      do_req(16'h0040, 1, n, d, ca);
      chk("drop_next_lat", n, LAT + 1);
      chk("drop_next_dat", d, rom(16'h0040));

      // Asynchronous reset in the middle of a miss.
      @(negedge clk);
      adr = 16'h0080; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("rstmid_cxa", cxa, 16'h0080);
      chk("rstmid_dat_before", dat, rom(16'h0040));
      #2 rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      #1;
      chk("rstmid_ack", ack, 0);
      chk("rstmid_dat", dat, 0);
      chk("rstmid_cxa0", cxa, 0);
      @(negedge clk);
      rst = 1'b1;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ack) bad = 1'b1;
      end
      chk("rstmid_noack", bad, 0);

`ifndef OC8051_CXROM_PREFETCH_EN
      // LATENCY=1 instance: four sequential requests.
      prev1 = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         a = 16'h0200 + 16'(4 * i);
         @(negedge clk);
         chk($sformatf("lat1_hold%0d", i), cxa1, prev1);
         chk($sformatf("lat1_idle_ack%0d", i), ack1, 0);
         adr1 = a; cyc1 = 1'b1; stb1 = 1'b1;
         @(negedge clk);
         chk($sformatf("lat1_acc%0d", i), cxa1, a);
         chk($sformatf("lat1_noack%0d", i), ack1, 0);
         @(negedge clk);
         chk($sformatf("lat1_ack%0d", i), ack1, 1);
         chk($sformatf("lat1_dat%0d", i), dat1, rom(a));
         cyc1 = 1'b0; stb1 = 1'b0;
         prev1 = a;
      end
`endif

      // Randomized traffic against timing rules derived from the bus behaviour.
      do_reset();
      have_prev = 1'b0;
      prev = '0;
      for (int t = 0; t < 60; t++) begin
         if (have_prev && ($urandom_range(0, 1) == 1))
            a = 16'(prev + 16'd4);
         else
            a = 16'($urandom) & 16'hFFFC;
         case ($urandom_range(0, 3))
            0:       g = 0;
            1:       g = 1;
            2:       g = LAT + 1;
            default: g = LAT + 3;
         endcase
         do_req(a, g, n, d, ca);
         chk("rnd_dat", d, rom(a));
`ifdef OC8051_CXROM_PREFETCH_EN
         if (have_prev && g >= LAT + 1)
            chk("rnd_lat", n, (a == 16'(prev + 16'd4)) ? 1 : LAT + 1);
         else
            chk("rnd_lat_bound", (n >= 1 && n <= LAT + 2), 1);
`else
         chk("rnd_lat", n, (g == 0 && have_prev) ? LAT + 2 : LAT + 1);
         chk("rnd_cxa", ca, a);
`endif
         prev = a;
         have_prev = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oc8051_cxrom_fetch.md
Name: oc8051_cxrom_fetch

Overview:
- Instruction-fetch bridge between the oc8051 instruction bus (wbi_*) and the fully-combinational cxrom.
- Registers the ROM address and models a configurable ROM access latency.
- Returns the 32-bit word to the core with a single-cycle ack.
- Optionally holds a one-entry sequential prefetch (addr+4) so straight-line code is acked in one cycle.

Parameters:
- LATENCY, 2, clock edges from cxrom_addr update to data capture (legal 1..7).
- AW, 16, address width (fixed by the cxrom interface).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- wbi_adr_i  in  16  byte address requested by the core
- wbi_cyc_i  in  1  bus cycle active
- wbi_stb_i  in  1  strobe, request valid
- wbi_dat_o  out  32  fetched word (bytes addr..addr+3)
- wbi_ack_o  out  1  one-cycle completion pulse
- cxrom_addr  out  16  registered address to the ROM
- cxrom_data_in  in  32  combinational ROM data for cxrom_addr

Behaviour:
- Reset (rst low, async):
  - wbi_ack_o=0, wbi_dat_o=0, cxrom_addr=0.
  - State IDLE, latency counter=0.
  - Prefetch entry invalid.
- Request accepted at a rising edge when wbi_cyc_i & wbi_stb_i & state IDLE & wbi_ack_o==0. No request is accepted in an ack cycle.
- States:
  - IDLE: no demand access.
  - MISS: demand access in progress.
  - PF: prefetch in progress; no demand pending.
- Miss, accepted at edge k:
  - cxrom_addr<=wbi_adr_i at edge k; counter loads LATENCY-1.
  - At edge k+LATENCY: wbi_dat_o<=cxrom_data_in and wbi_ack_o<=1 (high for exactly one cycle); state returns to IDLE.
- Hit (prefetch entry valid and pf_addr==wbi_adr_i) at edge k: wbi_dat_o<=pf_data and wbi_ack_o<=1 at edge k.
- Prefetch launch:
  - After any ack for address A, if the entry does not already hold A+4 it enters PF with cxrom_addr<=A+4 on the edge following the ack.
  - At completion the entry becomes valid with pf_addr=A+4.
- Request during PF:
  - Same address as in flight: merge. No restart; ack issues at the PF completion edge.
  - Different address: abort PF, entry invalid, start a miss at that edge.
- Address arithmetic is modulo 2^16: 0xFFFC+4=0x0000. Only 16-bit address compares are used.
- wbi_cyc_i low during MISS: abort, state IDLE, no ack, entry unchanged. A PF continues.
- wbi_dat_o holds its last value between acks.
- Async reset mid-access: clears everything immediately. No ack is issued after reset release.

Optional Feature:
- Macro OC8051_CXROM_PREFETCH_EN.
- Defined: prefetch entry and PF state as above.
- Undefined: no prefetch. Every access is a miss, acked at edge k+LATENCY. The PF state and entry are not synthesized.

Decomposition:
- Shared package: state encoding constants (IDLE/MISS/PF), LATENCY bounds, 32-bit word type, the wrap increment constant 4.
- One natural sub-module: oc8051_cxrom_pfbuf, holding the single prefetch entry (valid/addr/data, lookup, invalidate).

Test Plan:
- Reset then request 0x0000, LATENCY=2, ROM word 0x12345678: ack exactly 2 edges after acceptance, wbi_dat_o=0x12345678; cxrom_addr=0x0004 on the following edge.
- PREFETCH_EN: sequential 0x0000 then 0x0004: second ack 1 edge after acceptance with the word at 0x0004; the entry then refills 0x0008.
- Jump 0x0000 then 0x0100 while PF for 0x0004 is in flight: prefetch aborted, 0x0100 acked after 2 edges with correct data, and the 0x0004 data is never returned.
- Address 0xFFFC acked, prefetch addresses 0x0000; request 0x0000 hits.
- cyc dropped mid-MISS: no ack; next request 0x0040 completes normally. rst pulsed mid-MISS: all outputs 0 at once, no stray ack.
- Macro undefined, LATENCY=1: four sequential requests each acked 1 edge after acceptance; cxrom_addr only changes on acceptance.
